// File: rtl/muldiv_pkg.sv
// Shared encodings and helpers for the EX-stage iterative multiply/divide unit.
package muldiv_pkg;

  // Widest two's-complement value the helpers handle (a full 2*WIDTH product).
  localparam int MAX_W = 64;

  typedef enum logic [1:0] {
    OP_MULT  = 2'd0,
    OP_MULTU = 2'd1,
    OP_DIV   = 2'd2,
    OP_DIVU  = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2
  } state_e;

  // Two's-complement negate when neg is set; also yields |x| for a negative x.
  function automatic logic [MAX_W-1:0] cond_neg(input logic [MAX_W-1:0] x, input logic neg);
    return neg ? (~x + MAX_W'(1)) : x;
  endfunction

  function automatic logic is_signed_op(input op_e op);
    return (op == OP_MULT) || (op == OP_DIV);
  endfunction

  function automatic logic is_div_op(input op_e op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

endpackage

// File: rtl/ex_muldiv_unit_if.sv
// Request/response bundle between the ID/EX stage, the hazard logic and the mult/div unit.
interface ex_muldiv_unit_if #(
  parameter int WIDTH = 32
);
  import muldiv_pkg::*;

  logic             Start;
  op_e              Op;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Flush;
  logic             MtHi;
  logic             MtLo;
  logic             Busy;
  logic             Done;
  logic             DivZero;
  logic [WIDTH-1:0] HI;
  logic [WIDTH-1:0] LO;

  modport master (
    output Start, Op, A, B, Flush, MtHi, MtLo,
    input  Busy, Done, DivZero, HI, LO
  );

  modport slave (
    input  Start, Op, A, B, Flush, MtHi, MtLo,
    output Busy, Done, DivZero, HI, LO
  );

endinterface

// File: rtl/muldiv_step.sv
// One combinational iteration: shift-add multiply or restoring-divide step on an {hi,lo} pair.
module muldiv_step #(
  parameter int WIDTH = 32
) (
  input  logic             div_i,
  input  logic [WIDTH-1:0] hi_i,
  input  logic [WIDTH-1:0] lo_i,
  input  logic [WIDTH-1:0] opnd_i,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH-1:0] rem_sub;
  logic             rem_ge;

  always_comb begin
    // Multiply: lo holds the remaining multiplier bits, hi the partial product.
    mul_sum = {1'b0, hi_i} + (lo_i[0] ? {1'b0, opnd_i} : '0);
    // Divide: hi is the running remainder, lo shifts dividend out and quotient in.
    rem_sh  = {hi_i, lo_i[WIDTH-1]};
    rem_ge  = rem_sh >= {1'b0, opnd_i};
    rem_sub = WIDTH'(rem_sh - {1'b0, opnd_i});

    // NOTE: outputs get a value before any branch so no path can infer a latch.
    hi_o = mul_sum[WIDTH:1];
    lo_o = {mul_sum[0], lo_i[WIDTH-1:1]};
    if (div_i) begin
      hi_o = rem_ge ? rem_sub : rem_sh[WIDTH-1:0];
      lo_o = {lo_i[WIDTH-2:0], rem_ge};
    end
  end

endmodule

// File: rtl/ex_muldiv_unit.sv
// EX-stage multi-cycle multiply/divide unit owning HI/LO; one iteration per clock, WIDTH iterations.
module ex_muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             Clk,
  input  logic             Reset,
  ex_muldiv_unit_if.slave  bus
);

  localparam int CW = $clog2(WIDTH);

  state_e           state_q;
  logic [CW-1:0]    cnt_q;
  op_e              op_q;
  logic             sign_a_q;
  logic             sign_b_q;
  logic [WIDTH-1:0] acc_hi_q;
  logic [WIDTH-1:0] acc_lo_q;
  logic [WIDTH-1:0] opnd_q;
  logic [WIDTH-1:0] a_orig_q;
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;
  logic             done_q;
  logic             dz_q;

  logic             start_signed;
  logic             start_sign_a;
  logic             start_sign_b;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic [WIDTH-1:0] step_hi;
  logic [WIDTH-1:0] step_lo;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0] quo_fix;
  logic [WIDTH-1:0] rem_fix;
  logic             div_zero;

  // 0x80000000 negates to itself, which the datapath reads as unsigned 2^31.
  assign start_signed = is_signed_op(bus.Op);
  assign start_sign_a = start_signed & bus.A[WIDTH-1];
  assign start_sign_b = start_signed & bus.B[WIDTH-1];
  assign a_mag        = WIDTH'(cond_neg(MAX_W'(bus.A), start_sign_a));
  assign b_mag        = WIDTH'(cond_neg(MAX_W'(bus.B), start_sign_b));

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .div_i  (is_div_op(op_q)),
    .hi_i   (acc_hi_q),
    .lo_i   (acc_lo_q),
    .opnd_i (opnd_q),
    .hi_o   (step_hi),
    .lo_o   (step_lo)
  );

  // Quotient sign follows the operand signs; remainder follows the dividend.
  assign prod_fix = (2*WIDTH)'(cond_neg(MAX_W'({acc_hi_q, acc_lo_q}), sign_a_q ^ sign_b_q));
  assign quo_fix  = WIDTH'(cond_neg(MAX_W'(acc_lo_q), sign_a_q ^ sign_b_q));
  assign rem_fix  = WIDTH'(cond_neg(MAX_W'(acc_hi_q), sign_a_q));
  assign div_zero = is_div_op(op_q) && (opnd_q == '0);

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      op_q     <= OP_MULT;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      acc_hi_q <= '0;
      acc_lo_q <= '0;
      opnd_q   <= '0;
      a_orig_q <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
      dz_q     <= 1'b0;
    end else begin
      // NOTE: non-blocking only here, so every branch reads the pre-edge register values.
      done_q <= 1'b0;
      dz_q   <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (bus.Start && !bus.Flush) begin
            state_q  <= S_RUN;
            cnt_q    <= '0;
            op_q     <= bus.Op;
            sign_a_q <= start_sign_a;
            sign_b_q <= start_sign_b;
            a_orig_q <= bus.A;
            acc_hi_q <= '0;
            if (is_div_op(bus.Op)) begin
              acc_lo_q <= a_mag;
              opnd_q   <= b_mag;
            end else begin
              acc_lo_q <= b_mag;
              opnd_q   <= a_mag;
            end
          end else if (!bus.Start) begin
            if (bus.MtHi) hi_q <= bus.A;
            if (bus.MtLo) lo_q <= bus.A;
          end
        end
        S_RUN: begin
          if (bus.Flush) begin
            state_q <= S_IDLE;
          end else begin
            acc_hi_q <= step_hi;
            acc_lo_q <= step_lo;
            cnt_q    <= cnt_q + CW'(1);
            if (cnt_q == CW'(WIDTH-1)) state_q <= S_FIX;
          end
        end
        S_FIX: begin
          state_q <= S_IDLE;
          if (!bus.Flush) begin
            if (div_zero) begin
              hi_q <= a_orig_q;
              lo_q <= '1;
            end else if (is_div_op(op_q)) begin
              hi_q <= rem_fix;
              lo_q <= quo_fix;
            end else begin
              {hi_q, lo_q} <= prod_fix;
            end
            done_q <= 1'b1;
            dz_q   <= div_zero;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.Busy    = (state_q != S_IDLE);
  assign bus.Done    = done_q;
  assign bus.DivZero = dz_q;
  assign bus.HI      = hi_q;
  assign bus.LO      = lo_q;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Directed self-checking bench for ex_muldiv_unit: latency, signed/unsigned results, flush, MTHI/MTLO, reset.
module tb_ex_muldiv_unit;
  import muldiv_pkg::*;

  localparam int WIDTH = 32;

  logic Clk = 1'b0;
  logic Reset;
  always #5 Clk = ~Clk;

  ex_muldiv_unit_if #(.WIDTH(WIDTH)) bus ();

  ex_muldiv_unit #(.WIDTH(WIDTH)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the first negedge with Busy low (bounded).
  task automatic run_op(input op_e op, input logic [31:0] a, input logic [31:0] b,
                        output int nbusy, output logic done_early,
                        output logic done_end, output logic dz_end);
    bus.Start = 1'b1; bus.Op = op; bus.A = a; bus.B = b;
    @(negedge Clk);
    bus.Start = 1'b0;
    nbusy = 0;
    done_early = 1'b0;
    while (bus.Busy === 1'b1 && nbusy < 100) begin
      nbusy++;
      done_early |= bus.Done;
      @(negedge Clk);
    end
    done_end = bus.Done;
    dz_end   = bus.DivZero;
  endtask

  task automatic mt(input logic hi, input logic lo, input logic [31:0] a);
    bus.MtHi = hi; bus.MtLo = lo; bus.A = a;
    @(negedge Clk);
    bus.MtHi = 1'b0; bus.MtLo = 1'b0;
  endtask

  int   nb;
  logic de, dn, dz, seen;

  initial begin
    bus.Start = 1'b0; bus.Op = OP_MULT; bus.A = '0; bus.B = '0;
    bus.Flush = 1'b0; bus.MtHi = 1'b0; bus.MtLo = 1'b0;
    Reset = 1'b0;
    repeat (2) @(negedge Clk);
    check("rst_busy", bus.Busy, 0);
    check("rst_done", bus.Done, 0);
    check("rst_dz",   bus.DivZero, 0);
    check("rst_hi",   bus.HI, 0);
    check("rst_lo",   bus.LO, 0);
    Reset = 1'b1;
    @(negedge Clk);

    // MULTU max * max, with latency and pulse shape
    run_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, nb, de, dn, dz);
    check("multu_busy_cycles", nb, 33);
    check("multu_done_early", de, 0);
    check("multu_done", dn, 1);
    check("multu_dz", dz, 0);
    check("multu_hi", bus.HI, 32'hFFFF_FFFE);
    check("multu_lo", bus.LO, 32'h0000_0001);
    @(negedge Clk);
    check("multu_done_one_cycle", bus.Done, 0);

    run_op(OP_MULT, 32'hFFFF_FFFD, 32'd7, nb, de, dn, dz);
    check("mult_neg_hi", bus.HI, 32'hFFFF_FFFF);
    check("mult_neg_lo", bus.LO, 32'hFFFF_FFEB);

    run_op(OP_MULT, 32'h8000_0000, 32'h8000_0000, nb, de, dn, dz);
    check("mult_min_min_hi", bus.HI, 32'h4000_0000);
    check("mult_min_min_lo", bus.LO, 32'h0000_0000);

    run_op(OP_MULT, 32'h8000_0000, 32'd1, nb, de, dn, dz);
    check("mult_min_one", {bus.HI, bus.LO}, 64'hFFFF_FFFF_8000_0000);

    run_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, nb, de, dn, dz);
    check("div_m7_2_lo", bus.LO, 32'hFFFF_FFFD);
    check("div_m7_2_hi", bus.HI, 32'hFFFF_FFFF);

    run_op(OP_DIV, 32'd7, 32'hFFFF_FFFE, nb, de, dn, dz);
    check("div_7_m2_lo", bus.LO, 32'hFFFF_FFFD);
    check("div_7_m2_hi", bus.HI, 32'h0000_0001);

    run_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, nb, de, dn, dz);
    check("div_ovf_lo", bus.LO, 32'h8000_0000);
    check("div_ovf_hi", bus.HI, 32'h0000_0000);
    check("div_ovf_dz", dz, 0);

    run_op(OP_DIVU, 32'h0000_1234, 32'd0, nb, de, dn, dz);
    check("divu_z_busy_cycles", nb, 33);
    check("divu_z_done", dn, 1);
    check("divu_z_dz", dz, 1);
    check("divu_z_lo", bus.LO, 32'hFFFF_FFFF);
    check("divu_z_hi", bus.HI, 32'h0000_1234);
    @(negedge Clk);
    check("divu_z_dz_one_cycle", bus.DivZero, 0);

    run_op(OP_DIV, 32'hFFFF_FFF0, 32'd0, nb, de, dn, dz);
    check("div_z_neg", {bus.HI, bus.LO}, 64'hFFFF_FFF0_FFFF_FFFF);
    check("div_z_dz", dz, 1);

    // MTHI alone leaves LO; then MTLO
    mt(1'b1, 1'b0, 32'd5);
    check("mthi_hi", bus.HI, 32'd5);
    check("mthi_lo_kept", bus.LO, 32'hFFFF_FFFF);
    mt(1'b0, 1'b1, 32'd9);
    check("mtlo_lo", bus.LO, 32'd9);

    // Flush sampled at E0+10 during DIVU 100/7
    bus.Start = 1'b1; bus.Op = OP_DIVU; bus.A = 32'd100; bus.B = 32'd7;
    @(negedge Clk);
    bus.Start = 1'b0;
    repeat (9) @(negedge Clk);
    bus.Flush = 1'b1;
    @(negedge Clk);
    bus.Flush = 1'b0;
    check("flush_busy", bus.Busy, 0);
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      seen |= bus.Done;
      @(negedge Clk);
    end
    check("flush_no_done", seen, 0);
    check("flush_hi", bus.HI, 32'd5);
    check("flush_lo", bus.LO, 32'd9);

    run_op(OP_DIVU, 32'd100, 32'd7, nb, de, dn, dz);
    check("divu_after_flush_done", dn, 1);
    check("divu_after_flush_lo", bus.LO, 32'd14);
    check("divu_after_flush_hi", bus.HI, 32'd2);

    mt(1'b1, 1'b0, 32'hAA);
    check("mthi_aa", bus.HI, 32'hAA);
    check("mthi_aa_lo_kept", bus.LO, 32'd14);

    // MTLO and a second Start while busy are both ignored
    bus.Start = 1'b1; bus.Op = OP_MULTU; bus.A = 32'd3; bus.B = 32'd5;
    @(negedge Clk);
    bus.Start = 1'b0;
    @(negedge Clk);
    bus.MtLo = 1'b1; bus.Start = 1'b1; bus.Op = OP_DIVU; bus.A = 32'hDEAD; bus.B = 32'd1;
    @(negedge Clk);
    bus.MtLo = 1'b0; bus.Start = 1'b0;
    nb = 2;
    while (bus.Busy === 1'b1 && nb < 100) begin
      nb++;
      @(negedge Clk);
    end
    check("busy_ignore_cycles", nb, 33);
    check("busy_ignore_lo", bus.LO, 32'd15);
    check("busy_ignore_hi", bus.HI, 32'd0);
    @(negedge Clk);
    check("busy_ignore_no_restart", bus.Busy, 0);

    // Flush together with Start in IDLE: no operation begins
    bus.Start = 1'b1; bus.Flush = 1'b1; bus.Op = OP_MULTU; bus.A = 32'd2; bus.B = 32'd2;
    @(negedge Clk);
    bus.Start = 1'b0; bus.Flush = 1'b0;
    check("flush_start_busy", bus.Busy, 0);
    check("flush_start_lo", bus.LO, 32'd15);

    mt(1'b1, 1'b1, 32'h55);
    check("mt_both", {bus.HI, bus.LO}, 64'h0000_0055_0000_0055);

    // Asynchronous reset mid-RUN
    bus.Start = 1'b1; bus.Op = OP_MULTU; bus.A = 32'd3; bus.B = 32'd5;
    @(negedge Clk);
    bus.Start = 1'b0;
    repeat (5) @(negedge Clk);
    #2 Reset = 1'b0;
    #1;
    check("rst_mid_busy", bus.Busy, 0);
    check("rst_mid_hi", bus.HI, 0);
    check("rst_mid_lo", bus.LO, 0);
    @(negedge Clk);
    Reset = 1'b1;
    @(negedge Clk);
    check("rst_mid_idle", bus.Busy, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
